// File: rtl/axi_sid_tracker.sv
// Outstanding-transaction tracker for one AXI address channel: range-checks requests,
// keeps an age-ordered queue of in-flight source IDs and flags decode/unmatched-response errors.
module axi_sid_tracker #(
  parameter int                SID_W   = 7,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] LO_ADDR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] HI_ADDR = 32'h4FFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [SID_W-1:0]  s_sid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [SID_W-1:0]  m_sid,
  output logic              dec_err_pulse,
  output logic [SID_W-1:0]  dec_err_sid,
  input  logic              rsp_done,
  input  logic [SID_W-1:0]  rsp_sid,
  input  logic              err_clr,
  output logic              decode_err_reg,
  output logic              rsp_err_reg,
  output logic [SID_W:0]    sid_buffer0,
  output logic [SID_W:0]    sid_buffer1,
  output logic [SID_W:0]    sid_buffer2,
  output logic [SID_W:0]    sid_buffer3,
  output logic [2:0]        outstanding
);

  localparam int SLOT_W = SID_W + 1;
  localparam int DEPTH  = 4;

  logic [SLOT_W-1:0] slot_p1  [DEPTH];
  logic [SLOT_W-1:0] slot_nxt [DEPTH];
  logic [2:0]        cnt_p1, cnt_nxt, cnt_free;
  logic [1:0]        hit_idx, wr_idx;
  logic              in_range, not_full, alloc, oor_acc, hit, free;
  logic              dec_vld_p1, dec_err_p1, rsp_err_p1;
  logic [SID_W-1:0]  dec_sid_p1;

  // Offset compare: an address below LO_ADDR wraps to a value larger than the window size.
  assign in_range = (s_addr - LO_ADDR) <= (HI_ADDR - LO_ADDR);
  assign not_full = (cnt_p1 != 3'd4);
  assign s_ready  = in_range ? (m_ready & not_full) : 1'b1;
  assign m_valid  = s_valid & in_range & not_full;
  assign m_addr   = s_addr;
  assign m_sid    = s_sid;
  assign alloc    = m_valid & m_ready;
  assign oor_acc  = s_valid & ~in_range;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_p1[k][SLOT_W-1] && (slot_p1[k][SID_W-1:0] == rsp_sid)) begin
        hit     = 1'b1;
        hit_idx = k[1:0];
      end
    end
  end

  assign free = rsp_done & hit;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot_nxt[k] = slot_p1[k];
    cnt_free = cnt_p1 - {2'b00, free};
    wr_idx   = cnt_free[1:0];
    if (free) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (k[1:0] >= hit_idx) slot_nxt[k] = slot_p1[k+1];
      end
      slot_nxt[DEPTH-1] = '0;
    end
    // The new entry goes after the compacted queue, so it can never be the one freed.
    if (alloc) slot_nxt[wr_idx] = {1'b1, s_sid};
    cnt_nxt = cnt_free + {2'b00, alloc};
  end

  // ---- stage p1: registered queue, count and error state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) slot_p1[k] <= '0;
      cnt_p1     <= '0;
      dec_vld_p1 <= 1'b0;
      dec_sid_p1 <= '0;
      dec_err_p1 <= 1'b0;
      rsp_err_p1 <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_p1[k] <= slot_nxt[k];
      cnt_p1     <= cnt_nxt;
      dec_vld_p1 <= oor_acc;
      if (oor_acc) dec_sid_p1 <= s_sid;
      if (oor_acc)      dec_err_p1 <= 1'b1;
      else if (err_clr) dec_err_p1 <= 1'b0;
      if (rsp_done && !hit) rsp_err_p1 <= 1'b1;
      else if (err_clr)     rsp_err_p1 <= 1'b0;
    end
  end

  assign sid_buffer0    = slot_p1[0];
  assign sid_buffer1    = slot_p1[1];
  assign sid_buffer2    = slot_p1[2];
  assign sid_buffer3    = slot_p1[3];
  assign outstanding    = cnt_p1;
  assign dec_err_pulse  = dec_vld_p1;
  assign dec_err_sid    = dec_sid_p1;
  assign decode_err_reg = dec_err_p1;
  assign rsp_err_reg    = rsp_err_p1;

endmodule

// File: tb/tb_axi_sid_tracker.sv
// Scoreboard bench for axi_sid_tracker: a queue-based reference model predicts every cycle,
// a separate monitor compares the DUT against the predictions.
module tb_axi_sid_tracker;

  localparam logic [31:0] LO = 32'h0000_0000;
  localparam logic [31:0] HI = 32'h4FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_addr, m_addr;
  logic [6:0]  s_sid, m_sid, dec_err_sid, rsp_sid;
  logic        dec_err_pulse, rsp_done, err_clr, decode_err_reg, rsp_err_reg;
  logic [7:0]  sid_buffer0, sid_buffer1, sid_buffer2, sid_buffer3;
  logic [2:0]  outstanding;

  axi_sid_tracker #(.SID_W(7), .ADDR_W(32), .LO_ADDR(LO), .HI_ADDR(HI)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_sid(s_sid), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_sid(m_sid),
    .dec_err_pulse(dec_err_pulse), .dec_err_sid(dec_err_sid), .rsp_done(rsp_done),
    .rsp_sid(rsp_sid), .err_clr(err_clr), .decode_err_reg(decode_err_reg),
    .rsp_err_reg(rsp_err_reg), .sid_buffer0(sid_buffer0), .sid_buffer1(sid_buffer1),
    .sid_buffer2(sid_buffer2), .sid_buffer3(sid_buffer3), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            s_ready;
    logic            m_valid;
    logic [31:0]     addr;
    logic [6:0]      sid;
    logic [3:0][7:0] bufs;
    logic [2:0]      outst;
    logic            dec;
    logic            rsp;
    logic            pulse;
    logic [6:0]      dsid;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] mq[$];
  logic       m_dec, m_rsp, m_pulse;
  logic [6:0] m_dsid;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight IDs kept as a plain ordered list.
  task automatic cyc(input logic r, input logic v, input logic [31:0] a, input logic [6:0] sd,
                     input logic mr, input logic rd, input logic [6:0] rs, input logic ec);
    exp_t e;
    bit   inr, full, acc_in, acc_oor;
    int   hit;
    @(negedge clk);
    rst = r; s_valid = v; s_addr = a; s_sid = sd; m_ready = mr;
    rsp_done = rd; rsp_sid = rs; err_clr = ec;
    inr       = (a >= LO) && (a <= HI);
    full      = (mq.size() == 4);
    e.s_ready = inr ? (mr && !full) : 1'b1;
    e.m_valid = v && inr && !full;
    e.addr    = a;
    e.sid     = sd;
    acc_in    = v && inr && mr && !full;
    acc_oor   = v && !inr;
    if (r) begin
      mq.delete();
      m_dec = 0; m_rsp = 0; m_pulse = 0; m_dsid = '0;
    end else begin
      hit = -1;
      if (rd) for (int i = 0; i < mq.size(); i++) if (hit < 0 && mq[i] == rs) hit = i;
      if (rd && hit >= 0) mq.delete(hit);
      if (rd && hit < 0) m_rsp = 1; else if (ec) m_rsp = 0;
      if (acc_oor) m_dec = 1; else if (ec) m_dec = 0;
      if (acc_in) mq.push_back(sd);
      m_pulse = acc_oor;
      if (acc_oor) m_dsid = sd;
    end
    for (int i = 0; i < 4; i++) e.bufs[i] = (i < mq.size()) ? {1'b1, mq[i]} : 8'h00;
    e.outst = 3'(mq.size());
    e.dec = m_dec; e.rsp = m_rsp; e.pulse = m_pulse; e.dsid = m_dsid;
    sb.push_back(e);
  endtask

  task automatic req(input logic [6:0] sd);
    cyc(0, 1, 32'h0000_1000, sd, 1, 0, 7'h0, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
  endtask

  task automatic chk_bufs(input string name, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic [2:0] o);
    chk({name, "_b0"}, sid_buffer0, b0);
    chk({name, "_b1"}, sid_buffer1, b1);
    chk({name, "_b2"}, sid_buffer2, b2);
    chk({name, "_b3"}, sid_buffer3, b3);
    chk({name, "_out"}, outstanding, o);
  endtask

  // Monitor: combinational outputs before the edge, registered state after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("s_ready", s_ready, e.s_ready);
        chk("m_valid", m_valid, e.m_valid);
        if (e.m_valid) begin
          chk("m_addr", m_addr, e.addr);
          chk("m_sid", m_sid, e.sid);
        end
        @(posedge clk);
        #1;
        chk("sid_buffer0", sid_buffer0, e.bufs[0]);
        chk("sid_buffer1", sid_buffer1, e.bufs[1]);
        chk("sid_buffer2", sid_buffer2, e.bufs[2]);
        chk("sid_buffer3", sid_buffer3, e.bufs[3]);
        chk("outstanding", outstanding, e.outst);
        chk("decode_err_reg", decode_err_reg, e.dec);
        chk("rsp_err_reg", rsp_err_reg, e.rsp);
        chk("dec_err_pulse", dec_err_pulse, e.pulse);
        chk("dec_err_sid", dec_err_sid, e.dsid);
      end
    end
  end

  initial begin
    logic        r, v, mr, rd, ec;
    logic [31:0] a;
    logic [6:0]  sd, rs;
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000; corner[1] = 32'h4FFF_FFFF;
    corner[2] = 32'h5000_0000; corner[3] = 32'hFFFF_FFFF;
    rst = 1; s_valid = 0; s_addr = '0; s_sid = '0; m_ready = 0;
    rsp_done = 0; rsp_sid = '0; err_clr = 0;
    mq.delete(); m_dec = 0; m_rsp = 0; m_pulse = 0; m_dsid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bufs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    chk("reset_dec_err", decode_err_reg, 1'b0);
    chk("reset_rsp_err", rsp_err_reg, 1'b0);
    chk("reset_pulse", dec_err_pulse, 1'b0);

    // Fill, stall when full, free a middle entry, stalled request drains into slot 3
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    req(7'h11); req(7'h22); req(7'h33); req(7'h44);
    req(7'h55);
    #1;
    chk("full_s_ready", s_ready, 1'b0);
    chk("full_m_valid", m_valid, 1'b0);
    chk_bufs("full", 8'h91, 8'hA2, 8'hB3, 8'hC4, 3'd4);
    cyc(0, 1, 32'h0000_1000, 7'h55, 1, 1, 7'h22, 0);
    #1;
    chk("nobypass_s_ready", s_ready, 1'b0);
    req(7'h55);
    #1;
    chk_bufs("freed", 8'h91, 8'hB3, 8'hC4, 8'h00, 3'd3);
    chk("refill_s_ready", s_ready, 1'b1);
    idle();
    #1;
    chk_bufs("refill", 8'h91, 8'hB3, 8'hC4, 8'hD5, 3'd4);

    // Duplicate IDs: oldest match is removed
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    req(7'h05); req(7'h07); req(7'h05);
    cyc(0, 0, 32'h0, 7'h0, 1, 1, 7'h05, 0);
    idle();
    #1;
    chk_bufs("dup", 8'h87, 8'h85, 8'h00, 8'h00, 3'd2);

    // Out-of-range request and sticky flag behaviour
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    cyc(0, 1, 32'h6000_0000, 7'h0A, 0, 0, 7'h0, 0);
    #1;
    chk("oor_s_ready", s_ready, 1'b1);
    chk("oor_m_valid", m_valid, 1'b0);
    idle();
    #1;
    chk("oor_pulse", dec_err_pulse, 1'b1);
    chk("oor_sid", dec_err_sid, 7'h0A);
    chk("oor_flag", decode_err_reg, 1'b1);
    chk("oor_noalloc", outstanding, 3'd0);
    idle();
    #1;
    chk("oor_pulse_once", dec_err_pulse, 1'b0);
    chk("oor_flag_held", decode_err_reg, 1'b1);
    cyc(0, 0, 32'h0, 7'h0, 1, 0, 7'h0, 1);
    idle();
    #1;
    chk("clr_flag", decode_err_reg, 1'b0);
    cyc(0, 1, 32'hFFFF_FFFF, 7'h0B, 1, 0, 7'h0, 1);
    idle();
    #1;
    chk("clr_vs_set", decode_err_reg, 1'b1);

    // Same-cycle free and allocate
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    req(7'h01); req(7'h02);
    cyc(0, 1, 32'h0000_2000, 7'h03, 1, 1, 7'h01, 0);
    idle();
    #1;
    chk_bufs("swap", 8'h82, 8'h83, 8'h00, 8'h00, 3'd2);

    // Unmatched response, then reset with entries held
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    cyc(0, 0, 32'h0, 7'h0, 1, 1, 7'h7F, 0);
    idle();
    #1;
    chk("unmatched_flag", rsp_err_reg, 1'b1);
    chk("unmatched_out", outstanding, 3'd0);
    req(7'h21); req(7'h22); req(7'h23);
    cyc(1, 0, 32'h0, 7'h0, 1, 0, 7'h0, 0);
    idle();
    #1;
    chk_bufs("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       a = corner[$urandom_range(0, 3)];
        1, 2:    a = $urandom_range(32'h5000_0000, 32'hFFFF_FFFF);
        default: a = $urandom_range(32'h0000_0000, 32'h4FFF_FFFF);
      endcase
      sd = 7'($urandom_range(0, 7));
      mr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 2) == 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) rs = mq[$urandom_range(0, mq.size() - 1)];
      else rs = 7'($urandom_range(0, 127));
      ec = ($urandom_range(0, 19) == 0);
      cyc(r, v, a, sd, mr, rd, rs, ec);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sid_tracker.md
Name: axi_sid_tracker

Overview:
- Per-channel outstanding-transaction tracker for the AXI interconnect; one instance on the AW path, one on the AR path.
- Sits between a master-side address channel and the slave-side address channel.
- Range-checks each address and records the source ID of every accepted in-range transaction in a 4-entry age-ordered queue.
- Frees the entry when the matching response completes.
- Produces the sticky decode-error bit and the four packed SID bytes consumed by the APB config/status block.

Parameters:
- SID_W, 7, source ID width; stored byte is {occupied, sid}.
- ADDR_W, 32, address width.
- LO_ADDR, 32'h0000_0000, lowest legal address (inclusive).
- HI_ADDR, 32'h4FFF_FFFF, highest legal address (inclusive).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  master address valid.
- s_ready  out  1  master address ready.
- s_addr  in  ADDR_W  master address.
- s_sid  in  SID_W  master source ID.
- m_valid  out  1  forwarded address valid to slave side.
- m_ready  in  1  slave side ready.
- m_addr  out  ADDR_W  forwarded address (= s_addr).
- m_sid  out  SID_W  forwarded ID (= s_sid).
- dec_err_pulse  out  1  one-cycle strobe: out-of-range request accepted (to error-response generator).
- dec_err_sid  out  SID_W  SID of the rejected request, valid with dec_err_pulse.
- rsp_done  in  1  response completion (B handshake or R handshake with RLAST).
- rsp_sid  in  SID_W  SID of completing response.
- err_clr  in  1  clears both sticky error flags.
- decode_err_reg  out  1  sticky decode-error flag.
- rsp_err_reg  out  1  sticky unmatched-response flag.
- sid_buffer0..3  out  8 each  slot contents; slot 0 is oldest; 8'h00 means empty.
- outstanding  out  3  occupied-slot count, 0..4.

Behaviour:
- Reset (rst=1 at a posedge): all slots 8'h00, outstanding=0, both sticky flags 0, dec_err_pulse 0; dec_err_sid 0.
- Decode: in_range = (s_addr >= LO_ADDR) && (s_addr <= HI_ADDR), unsigned compare.
- In-range path, combinational:
  - m_valid = s_valid & in_range & (outstanding < 4).
  - s_ready = m_ready & (outstanding < 4).
  - Accept = s_valid & s_ready.
- Out-of-range path, combinational: m_valid=0, s_ready=1; accept is immediate.
- No full bypass: at outstanding=4, in-range requests stall even if rsp_done is asserted in the same cycle.
- Out-of-range accepts:
  - Next cycle: dec_err_pulse=1 for exactly one cycle, dec_err_sid=registered s_sid.
  - decode_err_reg <= 1.
  - No slot is allocated.
- Queue is a shift-down array:
  - Allocation writes {1'b1, s_sid} at index outstanding (after any same-cycle free).
  - Free targets the lowest index k with slot[k][7]=1 and slot[k][6:0]=rsp_sid; the oldest matching entry is removed.
  - Entries above k shift down one place; the top slot becomes 8'h00.
- Simultaneous free and allocate in one cycle:
  - Shift is applied first; the new entry lands at index outstanding-1; outstanding is unchanged.
  - A same-cycle allocate never matches the same-cycle free.
- rsp_done with no matching slot: queue unchanged, rsp_err_reg <= 1.
- Error flag priority: err_clr clears both flags, but a same-cycle set event wins (flag reads 1 next cycle).
- Slot and count outputs are registered; all updates are visible 1 cycle after the handshake.
- Reset asserted mid-operation: all state drops immediately. Any in-flight responses arriving after reset produce rsp_err_reg=1; this is intentional.
- Invariants:
  - Slots 0..outstanding-1 are occupied and the remainder are 8'h00.
  - outstanding never exceeds 4 and never underflows.

Test Plan:
- Reset, then 4 in-range requests with sids 0x11, 0x22, 0x33, 0x44 and m_ready=1 -> sid_buffer0..3 = 0x91, 0xA2, 0xB3, 0xC4; outstanding=4; 5th request sees s_ready=0 and m_valid=0.
- Full queue as above, rsp_done sid 0x22 -> buffers 0x91, 0xB3, 0xC4, 0x00; outstanding=3; the stalled request is then accepted and lands in slot3.
- Duplicate IDs: sids 0x05, 0x07, 0x05 queued, rsp_sid 0x05 -> buffers 0x87, 0x85, 0x00, 0x00 (oldest 0x05 removed).
- Out-of-range s_addr=32'h6000_0000, sid 0x0A -> s_ready=1 and m_valid=0 same cycle; next cycle dec_err_pulse=1 with dec_err_sid=0x0A; decode_err_reg=1 held; err_clr clears it; err_clr coincident with a new error leaves it at 1.
- outstanding=2 (0x81, 0x82), same-cycle rsp_done 0x01 and accept of sid 0x03 -> buffers 0x82, 0x83, 0x00, 0x00; outstanding=2.
- rsp_done sid 0x7F with empty queue -> rsp_err_reg=1, outstanding=0; rst asserted with 3 entries held -> all buffers 0x00 next cycle.
